// File: rtl/matrix_accel_feeder.sv
// matrix_accel_feeder: collects a serial weight/pixel stream, fires the matrix accelerator and returns its result.
// Define MATRIX_FEEDER_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module matrix_accel_feeder #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_WIDTH  = $clog2(KERNEL_SIZE**4)
`ifdef MATRIX_FEEDER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                                        Clk,
    input  logic                                        Rst,
    input  logic [DATA_WIDTH-1:0]                       in_data,
    input  logic                                        in_is_weight,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [ADDR_WIDTH-1:0]                       cfg_addr,
    input  logic                                        cfg_direct,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplier_out,
    output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] multiplicand_out,
    output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]          mStart,
    output logic [ADDR_WIDTH-1:0]                       AddressSelect,
    output logic                                        direct,
    input  logic [DATA_WIDTH-1:0]                       finalAccumulate,
    input  logic                                        finalReady,
    output logic [DATA_WIDTH-1:0]                       out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_err,
    output logic                                        weights_loaded
);
    localparam int N  = KERNEL_SIZE*KERNEL_SIZE;
    localparam int CW = $clog2(N+1);
    localparam logic [CW-1:0] N_C = CW'(N);

    typedef enum logic [1:0] {S_FILL, S_START, S_WAIT, S_OUTPUT} state_t;

    state_t                    state_q, state_d;
    logic [N*DATA_WIDTH-1:0]   w_q, w_d, p_q, p_d;
    logic [CW-1:0]             w_cnt_q, w_cnt_d, pix_cnt_q, pix_cnt_d;
    logic                      wl_q, wl_d, dir_q, dir_d, seen_q, seen_d, valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      accept;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0]             tmo_q, tmo_d;
    logic                      err_q, err_d;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready         = (state_q == S_FILL) && (in_is_weight || (pix_cnt_q < N_C));
    assign accept           = in_valid && in_ready;
    assign multiplier_out   = w_q;
    assign multiplicand_out = p_q;
    assign mStart           = {N{state_q == S_START}};
    assign AddressSelect    = addr_q;
    assign direct           = dir_q;
    assign out_data         = data_q;
    assign out_valid        = valid_q;
    assign weights_loaded   = wl_q;

    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        p_d       = p_q;
        w_cnt_d   = w_cnt_q;
        pix_cnt_d = pix_cnt_q;
        wl_d      = wl_q;
        addr_d    = addr_q;
        dir_d     = dir_q;
        seen_d    = seen_q;
        data_d    = data_q;
        valid_d   = valid_q;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        if (accept && in_is_weight) begin
            w_d[int'(w_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
            w_cnt_d = (w_cnt_q == N_C - CW'(1)) ? '0 : w_cnt_q + CW'(1);
            wl_d    = wl_q | (w_cnt_q == N_C - CW'(1));
        end
        if (accept && !in_is_weight) begin
            p_d[int'(pix_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = in_data;
            pix_cnt_d = pix_cnt_q + CW'(1);
        end
        case (state_q)
            S_FILL: begin
                // post-update counts so the final word's own cycle triggers START
                if (pix_cnt_d == N_C && wl_d) begin
                    state_d = S_START;
                    addr_d  = cfg_addr;
                    dir_d   = cfg_direct;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                seen_d  = 1'b0;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                // a stale high ready from the previous job must not be taken as completion
                seen_d = seen_q | ~finalReady;
                if (seen_q && finalReady) begin
                    data_d  = finalAccumulate;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end
`ifdef MATRIX_FEEDER_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_OUTPUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    valid_d   = 1'b0;
                    pix_cnt_d = '0;
                    state_d   = S_FILL;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_FILL;
            w_q       <= '0;
            p_q       <= '0;
            w_cnt_q   <= '0;
            pix_cnt_q <= '0;
            wl_q      <= 1'b0;
            addr_q    <= '0;
            dir_q     <= 1'b0;
            seen_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            p_q       <= p_d;
            w_cnt_q   <= w_cnt_d;
            pix_cnt_q <= pix_cnt_d;
            wl_q      <= wl_d;
            addr_q    <= addr_d;
            dir_q     <= dir_d;
            seen_q    <= seen_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
`ifdef MATRIX_FEEDER_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_matrix_accel_feeder.sv
// tb_matrix_accel_feeder: directed bench for matrix_accel_feeder with hand-computed expectations.
module tb_matrix_accel_feeder;
    localparam int DW = 32;
    localparam int N  = 9;
    localparam int AW = 7;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic [DW-1:0]   in_data = '0;
    logic            in_is_weight = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   cfg_addr = '0;
    logic            cfg_direct = 1'b0;
    logic [N*DW-1:0] multiplier_out, multiplicand_out;
    logic [N-1:0]    mStart;
    logic [AW-1:0]   AddressSelect;
    logic            direct;
    logic [DW-1:0]   finalAccumulate = '0;
    logic            finalReady = 1'b0;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_err;
    logic            weights_loaded;

    int checks = 0;
    int errors = 0;

    matrix_accel_feeder #(
        .DATA_WIDTH(DW),
        .KERNEL_SIZE(3)
`ifdef MATRIX_FEEDER_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .in_data(in_data), .in_is_weight(in_is_weight), .in_valid(in_valid), .in_ready(in_ready),
        .cfg_addr(cfg_addr), .cfg_direct(cfg_direct),
        .multiplier_out(multiplier_out), .multiplicand_out(multiplicand_out),
        .mStart(mStart), .AddressSelect(AddressSelect), .direct(direct),
        .finalAccumulate(finalAccumulate), .finalReady(finalReady),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_err(out_err), .weights_loaded(weights_loaded)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic w);
        in_data = d;
        in_is_weight = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_pixels(input int cnt, input logic [DW-1:0] d);
        for (int i = 0; i < cnt; i++) send(d, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_mstart", 64'(mStart), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_err", 64'(out_err), 64'h0);
        chk("rst_wl", 64'(weights_loaded), 64'h0);
        chk("rst_addr", 64'(AddressSelect), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        Rst = 1'b0;

        // window 1: weights 1..9, pixels of 1, accumulate 45
        cfg_addr = 7'h15;
        cfg_direct = 1'b1;
        finalAccumulate = 32'd45;
        for (int i = 1; i <= 9; i++) send(DW'(i), 1'b1);
        chk("w1_loaded", 64'(weights_loaded), 64'h1);
        chk("w1_no_start", 64'(mStart), 64'h0);
        send_pixels(8, 32'd1);
        chk("w1_8pix_no_start", 64'(mStart), 64'h0);
        send(32'd1, 1'b0);
        chk("w1_mstart", 64'(mStart), 64'h1FF);
        chk("w1_in_ready_busy", 64'(in_ready), 64'h0);
        chk("w1_addr", 64'(AddressSelect), 64'h15);
        chk("w1_direct", 64'(direct), 64'h1);
        chk("w1_wslot0", 64'(multiplier_out[0 +: DW]), 64'd1);
        chk("w1_wslot8", 64'(multiplier_out[8*DW +: DW]), 64'd9);
        chk("w1_pslot4", 64'(multiplicand_out[4*DW +: DW]), 64'd1);
        step();
        chk("w1_mstart_one_cycle", 64'(mStart), 64'h0);
        step();
        step();
        chk("w1_wait_no_valid", 64'(out_valid), 64'h0);
        finalReady = 1'b1;
        step();
        chk("w1_valid", 64'(out_valid), 64'h1);
        chk("w1_data", 64'(out_data), 64'd45);
        step();
        step();
        chk("w1_valid_held", 64'(out_valid), 64'h1);
        chk("w1_data_held", 64'(out_data), 64'd45);
        chk("w1_wslot8_stable", 64'(multiplier_out[8*DW +: DW]), 64'd9);
        out_ready = 1'b1;
        step();
        chk("w1_handshake", 64'(out_valid), 64'h0);
        chk("w1_refill_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b0;

        // window 2: finalReady stale-high into WAIT must be ignored until it drops
        finalReady = 1'b1;
        finalAccumulate = 32'd100;
        send_pixels(9, 32'd2);
        chk("w2_mstart_reuse_weights", 64'(mStart), 64'h1FF);
        step();
        chk("w2_wait1_no_capture", 64'(out_valid), 64'h0);
        step();
        chk("w2_wait2_no_capture", 64'(out_valid), 64'h0);
        finalReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("w2_low_no_capture", 64'(out_valid), 64'h0);
        end
        finalReady = 1'b1;
        step();
        chk("w2_valid", 64'(out_valid), 64'h1);
        chk("w2_data", 64'(out_data), 64'd100);
        out_ready = 1'b1;
        step();
        chk("w2_handshake", 64'(out_valid), 64'h0);
        out_ready = 1'b0;
        finalReady = 1'b0;

        // window 3: negative result held through 5 cycles of back-pressure
        cfg_addr = 7'h2A;
        cfg_direct = 1'b0;
        finalAccumulate = 32'hFFFF_FFF9;
        send_pixels(9, 32'd3);
        chk("w3_addr", 64'(AddressSelect), 64'h2A);
        chk("w3_direct", 64'(direct), 64'h0);
        step();
        step();
        finalReady = 1'b1;
        step();
        in_is_weight = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("w3_valid_held", 64'(out_valid), 64'h1);
            chk("w3_data_held", 64'(out_data), 64'hFFFF_FFF9);
            chk("w3_in_ready_low", 64'(in_ready), 64'h0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("w3_handshake", 64'(out_valid), 64'h0);
        out_ready = 1'b0;
        finalReady = 1'b0;

        // async reset while waiting on the accelerator
        send_pixels(9, 32'd4);
        step();
        Rst = 1'b1;
        #1;
        chk("arst_mstart", 64'(mStart), 64'h0);
        chk("arst_wl", 64'(weights_loaded), 64'h0);
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_addr", 64'(AddressSelect), 64'h0);
        chk("arst_wslot0", 64'(multiplier_out[0 +: DW]), 64'h0);
        step();
        Rst = 1'b0;

        // pixels first: no START until the 9th weight arrives
        send_pixels(9, 32'd5);
        chk("pf_no_start", 64'(mStart), 64'h0);
        in_is_weight = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("pf_pixel_blocked", 64'(in_ready), 64'h0);
        in_is_weight = 1'b1;
        #1;
        chk("pf_weight_open", 64'(in_ready), 64'h1);
        in_valid = 1'b0;
        for (int i = 10; i < 18; i++) send(DW'(i), 1'b1);
        chk("pf_8w_no_start", 64'(mStart), 64'h0);
        chk("pf_8w_not_loaded", 64'(weights_loaded), 64'h0);
        send(32'd18, 1'b1);
        chk("pf_start", 64'(mStart), 64'h1FF);
        chk("pf_wslot8", 64'(multiplier_out[8*DW +: DW]), 64'd18);
        finalAccumulate = 32'd7;
        step();
        step();
        finalReady = 1'b1;
        step();
        chk("pf_data", 64'(out_data), 64'd7);
        out_ready = 1'b1;
        step();
        chk("pf_handshake", 64'(out_valid), 64'h0);
        out_ready = 1'b0;
        finalReady = 1'b0;

`ifdef MATRIX_FEEDER_TIMEOUT_EN
        finalAccumulate = 32'd123;
        send_pixels(9, 32'd6);
        step();
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_not_yet", 64'(out_valid), 64'h0);
        end
        step();
        chk("to_valid", 64'(out_valid), 64'h1);
        chk("to_err", 64'(out_err), 64'h1);
        chk("to_data", 64'(out_data), 64'h0);
        out_ready = 1'b1;
        step();
        chk("to_err_clear", 64'(out_err), 64'h0);
        out_ready = 1'b0;
`else
        chk("no_timeout_err", 64'(out_err), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
